dice_roll_arbiter: RTL and testbench

- Shares one electronic dice instance (clk, rst, button in; throw[2:0] out; advances 1..6 while button high, holds when low, forces 000/111 to 001) between NUM_PLAYERS requesters.
- Grants round-robin, holds the dice button for a fixed roll window, waits for the throw to settle, then samples it.
- Returns the validated value to the granted player over a valid/ack handshake. Sits between the player input logic and the dice core.

---
 rtl/dice_roll_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dice_roll_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_arbiter.sv
// Round-robin owner of one shared electronic dice: rolls it, samples a legal throw, returns it.
// Grant one cycle after req; result_valid ROLL+SETTLE+2 cycles after the request edge; REPORT holds until ack.
module dice_roll_arbiter #(
   parameter int NUM_PLAYERS   = 4,
   parameter int ROLL_CYCLES   = 8,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_RETRY     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PLAYERS-1:0] req,
   input  logic [NUM_PLAYERS-1:0] ack,
   input  logic [2:0]             dice_throw,
   output logic                   dice_button,
   output logic [NUM_PLAYERS-1:0] grant,
   output logic [2:0]             result,
   output logic                   result_valid,
   output logic                   fault,
   output logic                   busy
);

   localparam int PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int CMAX = (ROLL_CYCLES > SETTLE_CYCLES) ? ROLL_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(MAX_RETRY + 2);

   localparam logic [PW-1:0]          LAST_RST  = PW'(NUM_PLAYERS - 1);
   localparam logic [NUM_PLAYERS-1:0] GRANT_LSB = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROLL,
      S_SETTLE,
      S_SAMPLE,
      S_REPORT
   } state_t;

   state_t                   state_q;
   logic [NUM_PLAYERS-1:0]   grant_q;
   logic [PW-1:0]            last_q;
   logic [CW-1:0]            cnt_q;
   logic [RW-1:0]            retry_q;
   logic                     button_q;
   logic [2:0]               result_q;
   logic                     rv_q;
   logic                     fault_q;
   logic                     busy_q;

   logic                     pick_vld_d;
   logic [PW-1:0]            pick_idx_d;
   logic [PW-1:0]            cand;
   int                       rr_j;
   logic                     throw_ok;

   // Search starts one past the last owner so every requester is reached within NUM_PLAYERS grants.
   always_comb begin
      pick_vld_d = 1'b0;
      pick_idx_d = last_q;
      cand       = last_q;
      rr_j       = 0;
      for (int i = 1; i <= NUM_PLAYERS; i++) begin
         rr_j = int'(last_q) + i;
         if (rr_j >= NUM_PLAYERS) begin
            rr_j = rr_j - NUM_PLAYERS;
         end
         cand = PW'(rr_j);
         if (!pick_vld_d && req[cand]) begin
            pick_vld_d = 1'b1;
            pick_idx_d = cand;
         end
      end
   end

   assign throw_ok = (dice_throw != 3'b000) && (dice_throw != 3'b111);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         last_q   <= LAST_RST;
         cnt_q    <= '0;
         retry_q  <= '0;
         button_q <= 1'b0;
         result_q <= 3'b000;
         rv_q     <= 1'b0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_vld_d) begin
                  grant_q  <= GRANT_LSB << pick_idx_d;
                  last_q   <= pick_idx_d;
                  cnt_q    <= CW'(ROLL_CYCLES - 1);
                  button_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_ROLL;
               end
            end
            S_ROLL: begin
               // last_q doubles as the granted index; an abort leaves it there so fairness advances.
               if (!req[last_q]) begin
                  grant_q  <= '0;
                  button_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else if (cnt_q == '0) begin
                  button_q <= 1'b0;
                  cnt_q    <= CW'(SETTLE_CYCLES - 1);
                  state_q  <= S_SETTLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= S_SAMPLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_SAMPLE: begin
               if (throw_ok) begin
                  result_q <= dice_throw;
                  fault_q  <= 1'b0;
                  retry_q  <= '0;
                  rv_q     <= 1'b1;
                  state_q  <= S_REPORT;
               end else if (retry_q < RW'(MAX_RETRY)) begin
                  retry_q <= retry_q + RW'(1);
               end else begin
                  result_q <= 3'b000;
                  fault_q  <= 1'b1;
                  retry_q  <= '0;
                  rv_q     <= 1'b1;
                  state_q  <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (ack[last_q]) begin
                  rv_q    <= 1'b0;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dice_button  = button_q;
   assign grant        = grant_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign fault        = fault_q;
   assign busy         = busy_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
   a_grant_stable  : assert property (@(posedge clk) disable iff (!rst)
                                      (busy && $past(busy)) |-> $stable(grant));
   a_valid_busy    : assert property (@(posedge clk) disable iff (!rst) result_valid |-> busy);

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Bench for dice_roll_arbiter: behavioural dice, table of round-robin rolls, scoreboard on result_valid,
// plus hand-written reset, abort, fault, retry and mid-roll reset sequences.
module tb_dice_roll_arbiter;

   localparam int NP  = 4;
   localparam int RC  = 8;
   localparam int SC  = 2;
   localparam int MR  = 3;
   localparam int LAT = RC + SC + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] req;
   logic [NP-1:0] ack;
   logic [2:0]    dice_throw;
   logic          dice_button;
   logic [NP-1:0] grant;
   logic [2:0]    result;
   logic          result_valid;
   logic          fault;
   logic          busy;

   logic [2:0]    dice_q;
   logic          force_bad;

   typedef struct {
      logic [NP-1:0] grant;
      logic [2:0]    result;
      logic          fault;
   } exp_t;

   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] grant;
      logic [2:0]    result;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vec[8];
   int   checks = 0;
   int   errors = 0;
   logic rv_prev = 1'b0;

   always #5 clk = ~clk;

   dice_roll_arbiter #(
      .NUM_PLAYERS  (NP),
      .ROLL_CYCLES  (RC),
      .SETTLE_CYCLES(SC),
      .MAX_RETRY    (MR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ack         (ack),
      .dice_throw  (dice_throw),
      .dice_button (dice_button),
      .grant       (grant),
      .result      (result),
      .result_valid(result_valid),
      .fault       (fault),
      .busy        (busy)
   );

   // Shared dice: 1..6 while the button is high, illegal codes snap back to 1.
   always @(posedge clk) begin
      if (!rst) begin
         dice_q <= 3'd1;
      end else if (dice_button) begin
         dice_q <= (dice_q >= 3'd6 || dice_q == 3'd0) ? 3'd1 : dice_q + 3'd1;
      end
   end
   assign dice_throw = force_bad ? 3'b111 : dice_q;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && result_valid === 1'b1 && !rv_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_result: got result %0d with no roll pending", result);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_grant",  int'(grant),  int'(mon_e.grant));
            chk("sb_result", int'(result), int'(mon_e.result));
            chk("sb_fault",  int'(fault),  int'(mon_e.fault));
         end
      end
      rv_prev = (result_valid === 1'b1);
   end

   task automatic run_roll(input logic [NP-1:0] rq, input logic [NP-1:0] eg, input logic [2:0] er,
                           input logic ef, input int elat, input int bad_ticks, input int hold_n,
                           input bit drop_req);
      int   lat = 0;
      int   btn = 0;
      exp_t e;
      e.grant  = eg;
      e.result = er;
      e.fault  = ef;
      req       = rq;
      force_bad = (bad_ticks > 0);
      sb.push_back(e);
      while (result_valid !== 1'b1 && lat < 40) begin
         tick;
         lat++;
         if (dice_button === 1'b1) btn++;
         if (lat == 1) chk("busy_after_grant", int'(busy), 1);
         if (result_valid !== 1'b1) chk("grant_held", int'(grant), int'(eg));
         if (lat == bad_ticks) force_bad = 1'b0;
      end
      chk("rv_latency", lat, elat);
      chk("button_cycles", btn, RC);
      for (int i = 0; i < hold_n; i++) begin
         ack = ~eg;
         tick;
         chk("hold_valid",  int'(result_valid), 1);
         chk("hold_result", int'(result), int'(er));
         chk("hold_grant",  int'(grant), int'(eg));
      end
      ack = eg;
      if (drop_req) req = '0;
      tick;
      ack       = '0;
      force_bad = 1'b0;
      chk("ack_grant_clear", int'(grant), 0);
      chk("ack_valid_clear", int'(result_valid), 0);
      chk("ack_busy_clear",  int'(busy), 0);
      chk("ack_result_kept", int'(result), int'(er));
      chk("ack_fault_kept",  int'(fault), int'(ef));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      req       = '0;
      ack       = '0;
      force_bad = 1'b0;

      vec[0] = '{4'b1011, 4'b0001, 3'd3};
      vec[1] = '{4'b1011, 4'b0010, 3'd5};
      vec[2] = '{4'b1011, 4'b1000, 3'd1};
      vec[3] = '{4'b1011, 4'b0001, 3'd3};
      vec[4] = '{4'b0110, 4'b0010, 3'd5};
      vec[5] = '{4'b0100, 4'b0100, 3'd1};
      vec[6] = '{4'b1001, 4'b1000, 3'd3};
      vec[7] = '{4'b1001, 4'b0001, 3'd5};

      // Reset held with every player requesting.
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_grant",  int'(grant), 0);
         chk("rst_button", int'(dice_button), 0);
         chk("rst_valid",  int'(result_valid), 0);
         chk("rst_busy",   int'(busy), 0);
      end
      chk("rst_result", int'(result), 0);
      chk("rst_fault",  int'(fault), 0);
      rst = 1'b1;
      req = '0;
      tick;
      chk("idle_no_req_busy", int'(busy), 0);

      // Single roll by player 2 with a long unacknowledged report and stray acks.
      run_roll(4'b0100, 4'b0100, 3'd3, 1'b0, LAT, 0, 5, 1'b1);

      rst = 1'b0;
      repeat (2) tick;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_roll(vec[i].req, vec[i].grant, vec[i].result, 1'b0, LAT, 0, 0, 1'b0);
      end

      // Abort: player 1 withdraws during its third roll cycle.
      req = 4'b0010;
      tick;
      chk("abort_grant",  int'(grant), 4'b0010);
      chk("abort_button", int'(dice_button), 1);
      tick;
      tick;
      req = '0;
      tick;
      chk("abort_grant_clear",  int'(grant), 0);
      chk("abort_button_clear", int'(dice_button), 0);
      chk("abort_busy_clear",   int'(busy), 0);
      chk("abort_no_valid",     int'(result_valid), 0);
      run_roll(4'b0011, 4'b0001, 3'd4, 1'b0, LAT, 0, 0, 1'b1);

      // Dice stuck at 111: four sample attempts then a fault report.
      run_roll(4'b0100, 4'b0100, 3'd0, 1'b1, LAT + MR, 1000, 0, 1'b1);

      // One illegal sample, then a legal throw.
      run_roll(4'b1000, 4'b1000, 3'd2, 1'b0, LAT + 1, LAT, 0, 1'b1);

      // Reset while the dice settles.
      req = 4'b0001;
      tick;
      chk("mid_grant", int'(grant), 4'b0001);
      repeat (8) tick;
      chk("mid_settle_button", int'(dice_button), 0);
      chk("mid_settle_busy",   int'(busy), 1);
      rst = 1'b0;
      tick;
      chk("mid_rst_grant",  int'(grant), 0);
      chk("mid_rst_button", int'(dice_button), 0);
      chk("mid_rst_valid",  int'(result_valid), 0);
      chk("mid_rst_busy",   int'(busy), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_fault",  int'(fault), 0);
      rst = 1'b1;
      run_roll(4'b1000, 4'b1000, 3'd3, 1'b0, LAT, 0, 0, 1'b1);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
